// File: rtl/pixel_clock_gen_if.sv
// pixel_clock_gen_if: lock/ratio control inputs and divided pixel-clock outputs
interface pixel_clock_gen_if #(parameter int DIV_W = 8);
    logic             pll_lock;
    logic [DIV_W-1:0] div_sel;
    logic             div_load;
    logic             out_clk;
    logic             pix_ce;
    logic             clk_ready;
    logic             pix_rst_n;
    logic [DIV_W-1:0] div_active;
    logic             lock_lost;
    modport master (
        output pll_lock, div_sel, div_load,
        input  out_clk, pix_ce, clk_ready, pix_rst_n, div_active, lock_lost
    );
    modport slave (
        input  pll_lock, div_sel, div_load,
        output out_clk, pix_ce, clk_ready, pix_rst_n, div_active, lock_lost
    );
endinterface

// File: rtl/pixel_clock_gen.sv
// pixel_clock_gen: lock-qualified, reprogrammable pixel clock divider with pixel-domain reset
module pixel_clock_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10,
    parameter int LOCK_STABLE = 1024
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    pixel_clock_gen_if.slave bus
);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    typedef enum logic [1:0] {S_WAIT, S_STAB, S_RUN} state_t;
    state_t           state, state_nxt;
    logic             lock_meta, lock_s;
    logic [SW-1:0]    stab_cnt, stab_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt, div_act, div_nxt, pend_div, pend_val, sel_clamp;
    logic             pend, pend_nxt, boundary, apply, run_nxt;
    logic             ce_seen, ce_seen_nxt;
    logic             out_clk_q, pix_ce_q, ready_q, pix_rst_q, lost_q;
    logic             out_clk_nxt, pix_ce_nxt, pix_rst_nxt, lost_nxt;

    always_ff @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) {lock_meta, lock_s} <= '0;
        else {lock_meta, lock_s} <= {bus.pll_lock, lock_meta};

    always_ff @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) begin
            state    <= S_WAIT;
            stab_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
        end

    always_comb begin
        state_nxt = state;
        stab_nxt  = '0;
        if (lock_s) begin
            stab_nxt = (stab_cnt == SW'(LOCK_STABLE)) ? stab_cnt : stab_cnt + SW'(1);
            if (state == S_WAIT) state_nxt = S_STAB;
            else if (state == S_STAB && stab_cnt >= SW'(LOCK_STABLE - 1)) state_nxt = S_RUN;
        end else begin
            state_nxt = S_WAIT;
        end
    end

    // Outputs are registered from next-state values so they change glitch-free on the edge
    always_comb begin
        sel_clamp   = (bus.div_sel < DIV_W'(2)) ? DIV_W'(2) : bus.div_sel;
        boundary    = cnt == div_act - DIV_W'(1);
        pend_val    = bus.div_load ? sel_clamp : pend_div;
        apply       = (bus.div_load || pend) && (state != S_RUN || boundary);
        div_nxt     = apply ? pend_val : div_act;
        pend_nxt    = (bus.div_load || pend) && !apply;
        run_nxt     = state_nxt == S_RUN;
        cnt_nxt     = (run_nxt && state == S_RUN && !boundary) ? cnt + DIV_W'(1) : '0;
        out_clk_nxt = run_nxt && cnt_nxt < (div_nxt >> 1);
        pix_ce_nxt  = run_nxt && cnt_nxt == '0;
        lost_nxt    = state == S_RUN && !run_nxt;
        ce_seen_nxt = run_nxt && (ce_seen || pix_ce_q);
        pix_rst_nxt = run_nxt && (pix_rst_q || (pix_ce_q && ce_seen));
    end

    always_ff @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) begin
            cnt       <= '0;
            div_act   <= DIV_W'(DEFAULT_DIV);
            pend_div  <= '0;
            pend      <= 1'b0;
            ce_seen   <= 1'b0;
            out_clk_q <= 1'b0;
            pix_ce_q  <= 1'b0;
            ready_q   <= 1'b0;
            pix_rst_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            div_act   <= div_nxt;
            pend_div  <= pend_val;
            pend      <= pend_nxt;
            ce_seen   <= ce_seen_nxt;
            out_clk_q <= out_clk_nxt;
            pix_ce_q  <= pix_ce_nxt;
            ready_q   <= run_nxt;
            pix_rst_q <= pix_rst_nxt;
            lost_q    <= lost_nxt;
        end

    assign bus.out_clk    = out_clk_q;
    assign bus.pix_ce     = pix_ce_q;
    assign bus.clk_ready  = ready_q;
    assign bus.pix_rst_n  = pix_rst_q;
    assign bus.div_active = div_act;
    assign bus.lock_lost  = lost_q;
endmodule

// File: tb/tb_pixel_clock_gen.sv
// tb_pixel_clock_gen: directed and random stimulus scored against a cycle-level reference model
module tb_pixel_clock_gen;
    localparam int LS = 16;
    localparam int DEF = 10;
    typedef struct packed {
        logic       oc;
        logic       ce;
        logic       rdy;
        logic       prst;
        logic       lost;
        logic [7:0] div;
    } outs_t;

    logic in_clk = 1'b0;
    logic in_rst_n;
    pixel_clock_gen_if #(.DIV_W(8)) bus ();

    pixel_clock_gen #(.DIV_W(8), .DEFAULT_DIV(DEF), .LOCK_STABLE(LS)) dut (
        .in_clk  (in_clk),
        .in_rst_n(in_rst_n),
        .bus     (bus)
    );

    always #5 in_clk = ~in_clk;

    outs_t exp_q[$];
    outs_t cur_exp;
    int    checks = 0;
    int    failures = 0;

    // Reference model: lock history, consecutive-lock streak, position within the period
    bit lk_q[$];
    int streak, pos, cur_div, pend_val, ce_count;
    bit pend, running;

    function automatic void model_reset();
        streak = 0; pos = 0; cur_div = DEF; pend = 0; pend_val = 0;
        running = 0; ce_count = 0;
        lk_q = {1'b0, 1'b0};
        cur_exp = '{oc: 0, ce: 0, rdy: 0, prst: 0, lost: 0, div: 8'(DEF)};
    endfunction

    function automatic void model_edge();
        bit was_run, lock_used, at_end;
        int sel;
        if (!in_rst_n) begin
            model_reset();
            return;
        end
        was_run   = running;
        lock_used = lk_q.pop_front();
        lk_q.push_back(bus.pll_lock);
        streak    = lock_used ? streak + 1 : 0;
        running   = streak >= LS;
        if (bus.div_load) begin
            sel = int'(bus.div_sel);
            pend = 1;
            pend_val = (sel < 2) ? 2 : sel;
        end
        at_end = was_run && pos == cur_div - 1;
        if (pend && (!was_run || at_end)) begin
            cur_div = pend_val;
            pend = 0;
        end
        pos = (running && was_run && !at_end) ? pos + 1 : 0;
        cur_exp.rdy  = running;
        cur_exp.oc   = running && pos < cur_div / 2;
        cur_exp.ce   = running && pos == 0;
        cur_exp.lost = was_run && !running;
        cur_exp.prst = running && ce_count >= 2;
        cur_exp.div  = 8'(cur_div);
        if (!running) ce_count = 0;
        else if (cur_exp.ce) ce_count++;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge in_clk);
            model_edge();
            exp_q.push_back(cur_exp);
            #1;
        end
    endtask

    task automatic load(input int sel);
        bus.div_sel = 8'(sel);
        bus.div_load = 1'b1;
        tick();
        bus.div_load = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 300 && !(running && pos == p); i++) tick();
    endtask

    // Called just after an edge: reset takes effect mid-cycle, so this cycle's expectation changes
    task automatic pulse_reset(input int n);
        in_rst_n = 1'b0;
        model_reset();
        exp_q[exp_q.size() - 1] = cur_exp;
        tick(n);
        in_rst_n = 1'b1;
    endtask

    initial begin : monitor
        outs_t e, a;
        int cyc = 0;
        forever begin
            @(negedge in_clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.out_clk, bus.pix_ce, bus.clk_ready, bus.pix_rst_n, bus.lock_lost, bus.div_active};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got oc=%b ce=%b rdy=%b prst=%b lost=%b div=%0d expected oc=%b ce=%b rdy=%b prst=%b lost=%b div=%0d",
                             cyc, a.oc, a.ce, a.rdy, a.prst, a.lost, a.div,
                             e.oc, e.ce, e.rdy, e.prst, e.lost, e.div);
                end
            end
        end
    end

    initial begin : stimulus
        in_rst_n = 1'b1;
        bus.pll_lock = 1'b0;
        bus.div_sel = '0;
        bus.div_load = 1'b0;
        model_reset();
        #1 in_rst_n = 1'b0;
        tick(3);
        in_rst_n = 1'b1;
        tick(2);
        bus.pll_lock = 1'b1;
        tick(45);
        bus.pll_lock = 1'b0;
        tick(5);
        bus.pll_lock = 1'b1;
        tick(8);
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        tick(45);
        wait_pos(3);
        load(5);
        tick(30);
        wait_pos(1);
        load(8);
        tick();
        load(12);
        tick(40);
        load(1);
        tick(20);
        load(0);
        tick(10);
        bus.pll_lock = 1'b0;
        tick(10);
        bus.pll_lock = 1'b1;
        tick(45);
        load(5);
        tick(30);
        pulse_reset(2);
        tick(40);
        for (int i = 0; i < 3000; i++) begin
            bus.div_load = ($urandom_range(0, 15) == 0);
            bus.div_sel = 8'($urandom_range(0, 20));
            if (bus.pll_lock) begin
                if ($urandom_range(0, 299) == 0) bus.pll_lock = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.pll_lock = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) pulse_reset($urandom_range(1, 3));
            else tick();
        end
        bus.div_load = 1'b0;
        tick(3);
        @(negedge in_clk);
        @(negedge in_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_clock_gen.md
# pixel_clock_gen

Parametrised pixel-clock generator for the VGA path. It takes the fast PLL output clock and the PLL lock flag. It produces a lock-qualified, runtime-reprogrammable divided pixel clock, a matching one-cycle clock enable, and a synchronised pixel-domain reset. Video modes can change without re-locking the PLL, and a lock loss cleanly stops and re-arms downstream timing logic.

## Interface
- DIV_W, 8: width of divide-ratio bus; ratios 2..2^DIV_W-1 supported
- DEFAULT_DIV, 10: divide ratio after reset (252 MHz / 10 = 25.2 MHz)
- LOCK_STABLE, 1024: consecutive synchronised-lock cycles required before running
- in_clk  in  1  fast clock from rPLL CLKOUT; all logic on rising edge
- in_rst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  PLL LOCK, asynchronous to in_clk
- div_sel  in  DIV_W  requested divide ratio
- div_load  in  1  one-cycle request to adopt div_sel
- out_clk  out  1  registered divided clock, glitch-free
- pix_ce  out  1  one-cycle strobe coincident with each out_clk rising edge
- clk_ready  out  1  high while in RUN
- pix_rst_n  out  1  active-low reset for pixel-domain logic
- div_active  out  DIV_W  ratio currently in effect
- lock_lost  out  1  one-cycle pulse when lock drops during RUN

## Operation
- pll_lock passes through a 2-flop synchroniser giving lock_s. Raw pll_lock is never used elsewhere.
- FSM states:
  - WAIT: lock_s low. Goes to STAB when lock_s is high.
  - STAB: stable counter increments while lock_s is high. Goes to RUN when the counter reaches LOCK_STABLE. Goes back to WAIT, with the counter cleared, if lock_s drops.
  - RUN: divider active. Goes to WAIT on lock_s low.
- Divider counter cnt runs 0..div_active-1, then wraps to 0. It is held at 0 outside RUN.
- out_clk is 1 when cnt < (div_active>>1) and 0 otherwise. Example: div 10 gives 5 high / 5 low; div 5 gives 2 high / 3 low.
- out_clk and pix_ce are both 0 outside RUN.
- pix_ce is 1 in every RUN cycle where cnt==0.
- Ratio change:
  - div_load captures div_sel into a pending register and sets a pending flag. If div_load repeats before the flag is applied, the last value wins.
  - div_sel values 0 or 1 are clamped to 2 at capture.
  - In RUN, the pending ratio moves into div_active on the cycle cnt==div_active-1, so the new period starts at the next cnt==0. A period is never truncated.
  - Outside RUN, the pending ratio is applied on the next cycle.
- pix_rst_n:
  - Goes low on entry to WAIT, and asynchronously on in_rst_n.
  - Goes high the cycle after the second pix_ce of a RUN episode, which guarantees two full pixel edges under reset.
- lock_lost pulses for exactly one cycle on the RUN→WAIT transition.
- Lock drop in STAB returns to WAIT without any lock_lost pulse.

## Timing
- Reset values: state WAIT, out_clk 0, pix_ce 0, clk_ready 0, pix_rst_n 0, lock_lost 0, div_active DEFAULT_DIV, pending flag 0, all counters 0.
- Lock-up latency: pll_lock sampled high at edge k gives lock_s high at k+2. clk_ready rises at k+2+LOCK_STABLE.
- The first RUN cycle has cnt=0, so out_clk=1, pix_ce=1 and clk_ready=1 are all asserted in that same cycle.
- Lock loss: lock_s low at edge j gives the following, all at j+1:
  - clk_ready=0
  - out_clk=0
  - pix_ce=0
  - pix_rst_n=0
  - lock_lost=1 for one cycle
  - the divider state is discarded
- div_load and a period boundary in the same cycle: the newly loaded value takes effect at that boundary.
- in_rst_n asserted mid-RUN asynchronously forces all outputs to their reset values, including div_active=DEFAULT_DIV.
- Width rules:
  - cnt and div_active are DIV_W bits; the comparison cnt==div_active-1 is computed without overflow.
  - The stable counter is $clog2(LOCK_STABLE+1) bits and saturates.

## Test plan
- LOCK_STABLE=16, DEFAULT_DIV=10, pll_lock rises at edge k → clk_ready and first pix_ce at k+18. out_clk is 5 high / 5 low. pix_ce every 10 cycles. pix_rst_n rises 1 cycle after the second pix_ce.
- pll_lock glitches low for 1 cycle during STAB → stable counter restarts, no lock_lost pulse, clk_ready delayed by the full 16 cycles after re-lock.
- In RUN at cnt=3, assert div_load with div_sel=5 → current 10-cycle period completes. Next period is 2 high / 3 low. div_active=5 at the boundary cycle.
- Two div_loads (8 then 12) within one period → only 12 is applied. Separately, div_sel=1 → div_active=2 and out_clk toggles every cycle.
- pll_lock drops in RUN → one-cycle lock_lost. out_clk, pix_ce, clk_ready and pix_rst_n all 0 on the next edge. Re-lock repeats the full 18-cycle start.
- in_rst_n pulsed low mid-RUN with div_active=5 → all outputs at reset values immediately, div_active=10 after release.
